// File: rtl/fix_pkg.sv
// Shared FIX protocol constants and the transmit checksum FSM state type.
package fix_pkg;

  localparam logic [7:0] FIX_SOH       = 8'h01;
  localparam logic [7:0] FIX_ASCII_0   = 8'h30;
  localparam logic [7:0] FIX_EQ        = 8'h3D;
  localparam logic [7:0] FIX_CSUM_TAG0 = 8'h31;
  localparam logic [7:0] FIX_CSUM_TAG1 = 8'h30;

  // Trailer "10=NNN<SOH>" is seven bytes, indexed 0..6.
  localparam logic [2:0] TRAIL_LAST_IDX = 3'd6;

  typedef enum logic {
    S_BODY  = 1'b0,
    S_TRAIL = 1'b1
  } csum_tx_state_t;

endpackage

// File: rtl/fix_csum_trailer_bin2dec3.sv
// Combinational 8-bit binary to three ASCII decimal digits (hundreds, tens, units).
module bin2dec3
  import fix_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] hundreds,
  output logic [7:0] tens,
  output logic [7:0] units
);

  logic [1:0] hund_d;
  logic [3:0] tens_d;
  logic [7:0] rem_h;
  logic [7:0] rem_t;
  logic       tens_found;

  // Compare-and-subtract keeps this divider-free: 200/100 first, then 90..10.
  always_comb begin
    hund_d     = 2'd0;
    rem_h      = value;
    tens_d     = 4'd0;
    rem_t      = 8'd0;
    tens_found = 1'b0;

    if (value >= 8'd200) begin
      hund_d = 2'd2;
      rem_h  = value - 8'd200;
    end else if (value >= 8'd100) begin
      hund_d = 2'd1;
      rem_h  = value - 8'd100;
    end

    rem_t = rem_h;
    for (int k = 9; k >= 1; k--) begin
      if (!tens_found && (rem_h >= 8'(k * 10))) begin
        tens_found = 1'b1;
        tens_d     = 4'(k);
        rem_t      = rem_h - 8'(k * 10);
      end
    end
  end

  assign hundreds = FIX_ASCII_0 + {6'd0, hund_d};
  assign tens     = FIX_ASCII_0 + {4'd0, tens_d};
  assign units    = FIX_ASCII_0 + rem_t;

endmodule

// File: rtl/fix_csum_trailer.sv
// Transmit FIX checksum: passes the body through and appends "10=NNN<SOH>".
// Optional FIX_CSUM_MON_EN adds checksum_o / csum_done_o monitor ports.
module fix_csum_trailer
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o,
  input  logic       ready_i
`ifdef FIX_CSUM_MON_EN
  ,
  output logic [7:0] checksum_o,
  output logic       csum_done_o
`endif
);

  csum_tx_state_t state, state_nxt;
  logic [7:0] sum;
  logic [7:0] csum;
  logic [2:0] idx;
  logic       run;

  logic       body_beat;
  logic       trail_adv;
  logic       trail_done;
  logic [7:0] dig_h;
  logic [7:0] dig_t;
  logic [7:0] dig_u;
  logic [7:0] trail_byte;

  assign body_beat  = run && (state == S_BODY) && valid_i && ready_i;
  assign trail_adv  = run && (state == S_TRAIL) && ready_i;
  assign trail_done = trail_adv && (idx == TRAIL_LAST_IDX);

  bin2dec3 u_bin2dec3 (
    .value    (csum),
    .hundreds (dig_h),
    .tens     (dig_t),
    .units    (dig_u)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BODY;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // The running sum clears on the closing beat so a new body can start right after the trailer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 8'd0;
      csum <= 8'd0;
      idx  <= 3'd0;
    end else begin
      if (body_beat) begin
        if (last_i) begin
          csum <= sum + data_i;
          sum  <= 8'd0;
          idx  <= 3'd0;
        end else begin
          sum <= sum + data_i;
        end
      end else if (trail_adv) begin
        idx <= trail_done ? 3'd0 : idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BODY:  if (body_beat && last_i) state_nxt = S_TRAIL;
      S_TRAIL: if (trail_done)          state_nxt = S_BODY;
      default: state_nxt = S_BODY;
    endcase
  end

  always_comb begin
    trail_byte = FIX_SOH;
    case (idx)
      3'd0:    trail_byte = FIX_CSUM_TAG0;
      3'd1:    trail_byte = FIX_CSUM_TAG1;
      3'd2:    trail_byte = FIX_EQ;
      3'd3:    trail_byte = dig_h;
      3'd4:    trail_byte = dig_t;
      3'd5:    trail_byte = dig_u;
      default: trail_byte = FIX_SOH;
    endcase
  end

  // Until the first edge after reset release every handshake output stays quiet.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = 8'h00;
    if (run) begin
      case (state)
        S_BODY: begin
          data_o  = data_i;
          valid_o = valid_i;
          ready_o = ready_i;
        end
        S_TRAIL: begin
          data_o  = trail_byte;
          valid_o = 1'b1;
          last_o  = (idx == TRAIL_LAST_IDX);
        end
        default: ;
      endcase
    end
  end

`ifdef FIX_CSUM_MON_EN
  assign checksum_o  = csum;
  assign csum_done_o = trail_done;
`endif

endmodule

// File: tb/tb_fix_csum_trailer.sv
// Scoreboard bench for fix_csum_trailer: driver queues expected bytes, monitor checks them.
module tb_fix_csum_trailer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       last_o;
  logic       ready_i;

  logic [8:0] exp_q[$];
  int applied;
  int miscompares;

  fix_csum_trailer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, act, req);
    end
  endtask

  // Monitor: every accepted output byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {last_o, data_o}, 9'h1FF);
      end else begin
        check("out_byte", {last_o, data_o}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] digit(input int v);
    return 8'(8'h30 + v);
  endfunction

  task automatic push_trailer(input int cs);
    exp_q.push_back({1'b0, 8'h31});
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h3D});
    exp_q.push_back({1'b0, digit(cs / 100)});
    exp_q.push_back({1'b0, digit((cs / 10) % 10)});
    exp_q.push_back({1'b0, digit(cs % 10)});
    exp_q.push_back({1'b1, 8'h01});
  endtask

  // Drives a body starting #1 after a posedge; returns #1 after the last beat's edge.
  task automatic applyBody(input logic [7:0] bytes[$], input int cs);
    for (int i = 0; i < bytes.size(); i++) begin
      data_i  = bytes[i];
      valid_i = 1'b1;
      last_i  = (i == bytes.size() - 1);
      exp_q.push_back({1'b0, bytes[i]});
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = 8'hEE;
    push_trailer(cs);
  endtask

  // Full message with ready held high: the trailer must take exactly 7 cycles.
  task automatic applyStimulus(input logic [7:0] bytes[$], input int cs, input bit chk_ready);
    applyBody(bytes, cs);
    for (int c = 0; c < 7; c++) begin
      valid_i = 1'b1;
      data_i  = 8'h77;
      if (chk_ready) begin
        @(negedge clk);
        check("ready_in_trailer", {8'd0, ready_o}, 9'd0);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check(name, 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] m[$];
    applied     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    data_i  = 8'hAA;
    valid_i = 1'b1;
    last_i  = 1'b0;
    ready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {valid_o, ready_o, last_o, data_o} , 11'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("run0_outputs", {valid_o, ready_o, last_o, data_o}, 11'h0);
    valid_i = 1'b0;
    @(posedge clk); #1;

    m = '{8'h41, 8'h42, 8'h01};
    applyStimulus(m, 132, 1'b0);
    checkOutput("drain_132");

    m = '{8'hFF, 8'hFF, 8'h03};
    applyStimulus(m, 1, 1'b0);
    checkOutput("drain_001");

    m = '{8'h00};
    applyStimulus(m, 0, 1'b1);
    checkOutput("drain_000");

    // Stall at idx 3: hundreds digit '1' of 132 must hold for 4 cycles.
    m = '{8'h41, 8'h42, 8'h01};
    applyBody(m, 132);
    repeat (3) begin @(posedge clk); #1; end
    ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_hold", {valid_o, last_o, data_o}, {1'b1, 1'b0, 8'h31} );
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("stall_len", 9'(exp_q.size()), 9'd0);
    checkOutput("drain_stall");

    m = '{8'h41, 8'h42, 8'h01};
    applyStimulus(m, 132, 1'b0);
    m = '{8'h10};
    applyStimulus(m, 16, 1'b0);
    checkOutput("drain_b2b");

    // Abort mid-trailer after idx 0 and 1 were accepted.
    m = '{8'h41, 8'h42, 8'h01};
    applyBody(m, 132);
    repeat (2) begin @(posedge clk); #1; end
    rst_n   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h55;
    exp_q.delete();
    @(negedge clk);
    check("midreset_outputs", {valid_o, ready_o, last_o, data_o}, 11'h0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    m = '{8'h05};
    applyStimulus(m, 5, 1'b0);
    checkOutput("drain_005");
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fix_csum_trailer.md
# fix_csum_trailer

Transmit-side FIX checksum generator. It sits between the outbound message builder and the line serializer. It passes the message body through byte by byte and keeps a running mod-256 sum. When the body ends, it appends the FIX standard trailer `10=NNN<SOH>`, where NNN is the three-digit ASCII decimal value of the sum. It is the transmit counterpart of the receive-side checksum block.

## Interface
- No parameters. Widths are fixed by the protocol.
- `clk` in 1: single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_i` in 8: body byte from the message builder.
- `valid_i` in 1: `data_i` is valid.
- `last_i` in 1: qualifies the final body byte, i.e. the SOH that closes the last body field.
- `ready_o` out 1: the block accepts the body byte.
- `data_o` out 8: byte to the serializer.
- `valid_o` out 1: `data_o` is valid.
- `last_o` out 1: asserted on the trailer's closing SOH.
- `ready_i` in 1: the serializer accepts the byte.

## Operation
- States: `S_BODY` and `S_TRAIL`. A 3-bit trailer index `idx` counts 0..6.
- `S_BODY` is pass-through:
  - `data_o = data_i`, `valid_o = valid_i`, `ready_o = ready_i`, `last_o = 0`.
  - A beat is `valid_i && ready_o`.
  - On each beat, `sum <= sum + data_i`, truncated to 8 bits (wraps mod 256).
- On a beat with `last_i = 1`:
  - `csum <= sum + data_i` (mod 256), `sum <= 0`, `idx <= 0`.
  - Next state is `S_TRAIL`.
- `S_TRAIL`:
  - `ready_o = 0`, `valid_o = 1`.
  - `data_o` by `idx`: 0x31 ('1'), 0x30 ('0'), 0x3D ('='), hundreds digit, tens digit, units digit, 0x01.
  - A digit byte is 0x30 + the decimal digit of `csum`. Example: 7 gives "007"; 255 gives "255".
  - `idx` advances only when `ready_i = 1`.
  - `last_o = 1` while `idx == 6`.
  - When `idx == 6` and `ready_i = 1`: next state is `S_BODY`, `idx <= 0`.
- Boundary conditions:
  - A `last_i` beat that is also the first byte of the body is legal. The trailer covers that single byte.
  - `valid_i` seen in `S_TRAIL` is ignored and not consumed, because `ready_o = 0`.
  - A new body may begin the cycle after the trailer SOH is accepted. `sum` is already 0 at that point.
  - Reset asserted mid-body or mid-trailer aborts the message. State returns to `S_BODY` with `sum`, `csum` and `idx` all 0. No partial trailer is emitted.
- Reset state:
  - `state = S_BODY`, `sum = 0`, `csum = 0`, `idx = 0`, `run = 0`.
  - `run` is a flag that goes to 1 on the first clock edge after `rst_n` deasserts.
  - While `run = 0`: `ready_o`, `valid_o` and `last_o` are 0, and `data_o` is 0x00.

## Timing
- Body path is combinational: zero latency, no added bubbles.
- The first trailer byte is presented the cycle after the `last_i` beat.
- With `ready_i` held high, the trailer takes exactly 7 cycles.
- Stall rule: while `valid_o = 1` and `ready_i = 0`, `data_o` and `last_o` hold stable.
- The decimal digits are computed combinationally from the registered `csum`. No extra cycle is needed.

## Configuration
- `FIX_CSUM_MON_EN`:
  - Defined: adds output port `checksum_o[7:0]` and output port `csum_done_o`.
  - `checksum_o` is the registered `csum` and holds its value until the next `last_i` beat.
  - `csum_done_o` is a one-cycle pulse on the cycle the trailer SOH is accepted.
  - Both ports reset to 0.
  - Undefined: neither port exists, and trailer behaviour is identical.

## Structure
- Shared package `fix_pkg` holds:
  - Constants `FIX_SOH = 8'h01`, `FIX_ASCII_0 = 8'h30`, `FIX_EQ = 8'h3D`.
  - Checksum tag bytes `FIX_CSUM_TAG0 = 8'h31` and `FIX_CSUM_TAG1 = 8'h30`.
  - The state enum `csum_tx_state_t`.
- One sub-module, `bin2dec3`:
  - Input: 8-bit value.
  - Outputs: three 8-bit ASCII digits.
  - Purely combinational. Uses compare-and-subtract against 200/100, then 90..10.

## Test plan
- Body 0x41, 0x42, 0x01 (last), `ready_i = 1` → `data_o` passes through, then "10=132" followed by 0x01. `last_o` is high only on that final 0x01.
- Body 0xFF, 0xFF, 0x03 (last) → sum wraps to 1 → trailer digits "001".
- Single byte 0x00 with `last_i = 1` → "10=000" + SOH. `ready_o = 0` for all 7 trailer cycles.
- Trailer with `ready_i = 0` for 4 cycles at `idx = 3` → `data_o` holds 0x31 ('1', hundreds digit of 132) stable. Total trailer length is 11 cycles.
- Two back-to-back messages, 0x41, 0x42, 0x01 then 0x10 (last) → second trailer is "10=016". This checks that the sum is cleared.
- `rst_n` pulsed low at `idx = 2` → outputs are 0 during reset. The next body 0x05 (last) yields "10=005". No leftover trailer bytes appear.
